// File: rtl/tcam_arbiter.sv
// Shares one tcam between a management port and two round-robin search clients.
// States: IDLE arbitrate | WRITE/CLEAR mgmt strobe | SEARCH await valid | ACK await valid low | MDONE/SDONE done pulse
module tcam_arbiter #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_req,
  input  logic                  m_op,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [WORD_WIDTH-1:0] m_word,
  input  logic [WORD_WIDTH-1:0] m_mask,
  input  logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_done,
  input  logic                  s0_req,
  input  logic [WORD_WIDTH-1:0] s0_word,
  output logic                  s0_done,
  output logic                  s0_hit,
  output logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s1_req,
  input  logic [WORD_WIDTH-1:0] s1_word,
  output logic                  s1_done,
  output logic                  s1_hit,
  output logic [DATA_WIDTH-1:0] s1_data,
  output logic                  busy,
  output logic                  tcam_req,
  output logic                  tcam_opcode,
  output logic                  tcam_clr,
  output logic [WORD_WIDTH-1:0] tcam_word,
  output logic [WORD_WIDTH-1:0] tcam_mask,
  output logic [ADDR_WIDTH-1:0] tcam_addr,
  output logic [DATA_WIDTH-1:0] tcam_data,
  output logic                  tcam_ack,
  input  logic                  tcam_valid,
  input  logic [DATA_WIDTH-1:0] tcam_data_out
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_CLEAR, S_SEARCH, S_ACK, S_MDONE, S_SDONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rr_q, rr_d;
  logic                  gnt_q, gnt_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  pick;

  logic                  tcam_req_q, tcam_req_d;
  logic                  tcam_opcode_q, tcam_opcode_d;
  logic                  tcam_clr_q, tcam_clr_d;
  logic                  tcam_ack_q, tcam_ack_d;
  logic [WORD_WIDTH-1:0] tcam_word_q, tcam_word_d;
  logic [WORD_WIDTH-1:0] tcam_mask_q, tcam_mask_d;
  logic [ADDR_WIDTH-1:0] tcam_addr_q, tcam_addr_d;
  logic [DATA_WIDTH-1:0] tcam_data_q, tcam_data_d;
  logic                  m_done_q, m_done_d;
  logic                  s0_done_q, s0_done_d;
  logic                  s1_done_q, s1_done_d;
  logic                  s0_hit_q, s0_hit_d;
  logic                  s1_hit_q, s1_hit_d;
  logic [DATA_WIDTH-1:0] s0_data_q, s0_data_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    gnt_d         = gnt_q;
    hit_d         = hit_q;
    res_d         = res_q;
    tcam_opcode_d = tcam_opcode_q;
    tcam_word_d   = tcam_word_q;
    tcam_mask_d   = tcam_mask_q;
    tcam_addr_d   = tcam_addr_q;
    tcam_data_d   = tcam_data_q;
    s0_hit_d      = s0_hit_q;
    s0_data_d     = s0_data_q;
    s1_hit_d      = s1_hit_q;
    s1_data_d     = s1_data_q;
    // on a tie the client not granted last time wins
    pick          = (s0_req && s1_req) ? ~rr_q : s1_req;

    case (state_q)
      S_IDLE: begin
        if (m_req) begin
          state_d       = m_op ? S_CLEAR : S_WRITE;
          tcam_opcode_d = 1'b0;
          tcam_addr_d   = m_addr;
          tcam_word_d   = m_word;
          tcam_mask_d   = m_mask;
          tcam_data_d   = m_data;
        end else if (s0_req || s1_req) begin
          state_d       = S_SEARCH;
          gnt_d         = pick;
          rr_d          = pick;
          tcam_opcode_d = 1'b1;
          tcam_word_d   = pick ? s1_word : s0_word;
          tcam_mask_d   = '1;
          cnt_d         = CNT_LOAD;
        end
      end
      S_WRITE, S_CLEAR: state_d = S_MDONE;
      S_SEARCH: begin
        if (tcam_valid) begin
          hit_d   = 1'b1;
          res_d   = tcam_data_out;
          cnt_d   = CNT_LOAD;
          state_d = S_ACK;
        end else if (cnt_q == '0) begin
          hit_d   = 1'b0;
          res_d   = '0;
          state_d = S_SDONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACK: begin
        if (!tcam_valid || cnt_q == '0) state_d = S_SDONE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are decoded from the next state so they appear registered with the state
    tcam_req_d = (state_d == S_WRITE) || (state_d == S_SEARCH);
    tcam_clr_d = (state_d == S_CLEAR);
    tcam_ack_d = (state_d == S_ACK);
    m_done_d   = (state_d == S_MDONE);
    s0_done_d  = (state_d == S_SDONE) && !gnt_d;
    s1_done_d  = (state_d == S_SDONE) && gnt_d;
    busy_d     = (state_d != S_IDLE);
    if (s0_done_d) begin
      s0_hit_d  = hit_d;
      s0_data_d = res_d;
    end
    if (s1_done_d) begin
      s1_hit_d  = hit_d;
      s1_data_d = res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rr_q          <= 1'b1;
      gnt_q         <= 1'b0;
      hit_q         <= 1'b0;
      res_q         <= '0;
      tcam_req_q    <= 1'b0;
      tcam_opcode_q <= 1'b0;
      tcam_clr_q    <= 1'b0;
      tcam_ack_q    <= 1'b0;
      tcam_word_q   <= '0;
      tcam_mask_q   <= '0;
      tcam_addr_q   <= '0;
      tcam_data_q   <= '0;
      m_done_q      <= 1'b0;
      s0_done_q     <= 1'b0;
      s1_done_q     <= 1'b0;
      s0_hit_q      <= 1'b0;
      s0_data_q     <= '0;
      s1_hit_q      <= 1'b0;
      s1_data_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_q          <= rr_d;
      gnt_q         <= gnt_d;
      hit_q         <= hit_d;
      res_q         <= res_d;
      tcam_req_q    <= tcam_req_d;
      tcam_opcode_q <= tcam_opcode_d;
      tcam_clr_q    <= tcam_clr_d;
      tcam_ack_q    <= tcam_ack_d;
      tcam_word_q   <= tcam_word_d;
      tcam_mask_q   <= tcam_mask_d;
      tcam_addr_q   <= tcam_addr_d;
      tcam_data_q   <= tcam_data_d;
      m_done_q      <= m_done_d;
      s0_done_q     <= s0_done_d;
      s1_done_q     <= s1_done_d;
      s0_hit_q      <= s0_hit_d;
      s0_data_q     <= s0_data_d;
      s1_hit_q      <= s1_hit_d;
      s1_data_q     <= s1_data_d;
      busy_q        <= busy_d;
    end
  end

  assign tcam_req    = tcam_req_q;
  assign tcam_opcode = tcam_opcode_q;
  assign tcam_clr    = tcam_clr_q;
  assign tcam_ack    = tcam_ack_q;
  assign tcam_word   = tcam_word_q;
  assign tcam_mask   = tcam_mask_q;
  assign tcam_addr   = tcam_addr_q;
  assign tcam_data   = tcam_data_q;
  assign m_done      = m_done_q;
  assign s0_done     = s0_done_q;
  assign s1_done     = s1_done_q;
  assign s0_hit      = s0_hit_q;
  assign s0_data     = s0_data_q;
  assign s1_hit      = s1_hit_q;
  assign s1_data     = s1_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tcam_arbiter.sv
// Scoreboard bench for tcam_arbiter with a behavioural tcam model.
module tb_tcam_arbiter;
  localparam int WW = 8, AW = 4, DW = 8, TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic m_req, m_op, m_done;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_word, m_mask;
  logic [DW-1:0] m_data;
  logic s0_req, s0_done, s0_hit, s1_req, s1_done, s1_hit;
  logic [WW-1:0] s0_word, s1_word;
  logic [DW-1:0] s0_data, s1_data;
  logic busy, tcam_req, tcam_opcode, tcam_clr, tcam_ack;
  logic [WW-1:0] tcam_word, tcam_mask;
  logic [AW-1:0] tcam_addr;
  logic [DW-1:0] tcam_data;
  logic tcam_valid = 1'b0;
  logic [DW-1:0] tcam_data_out = '0;

  tcam_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_op(m_op), .m_addr(m_addr), .m_word(m_word), .m_mask(m_mask),
    .m_data(m_data), .m_done(m_done),
    .s0_req(s0_req), .s0_word(s0_word), .s0_done(s0_done), .s0_hit(s0_hit), .s0_data(s0_data),
    .s1_req(s1_req), .s1_word(s1_word), .s1_done(s1_done), .s1_hit(s1_hit), .s1_data(s1_data),
    .busy(busy), .tcam_req(tcam_req), .tcam_opcode(tcam_opcode), .tcam_clr(tcam_clr),
    .tcam_word(tcam_word), .tcam_mask(tcam_mask), .tcam_addr(tcam_addr), .tcam_data(tcam_data),
    .tcam_ack(tcam_ack), .tcam_valid(tcam_valid), .tcam_data_out(tcam_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int srch_cycles = 0, clr_cycles = 0, m_pending = 0;
  int l0, l1, l2;
  logic [27:0] wr_q[$];
  logic [8:0]  s_q0[$], s_q1[$];
  int          order_q[$];
  logic [8:0]  last_res [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int enc_order();
    int v = 0;
    foreach (order_q[i]) v = v * 4 + order_q[i] + 1;
    order_q.delete();
    return v;
  endfunction

  // tcam model: 16 entries, lowest matching address wins, valid only on a hit
  logic          t_vld [16] = '{default: 1'b0};
  logic [WW-1:0] t_wrd [16] = '{default: '0};
  logic [WW-1:0] t_msk [16] = '{default: '0};
  logic [DW-1:0] t_dat [16] = '{default: '0};
  always @(posedge clk) begin : tcam_model
    logic          f;
    logic [DW-1:0] fd;
    f  = 1'b0;
    fd = '0;
    for (int i = 15; i >= 0; i--)
      if (t_vld[i] && (((t_wrd[i] ^ tcam_word) & t_msk[i]) == '0)) begin
        f  = 1'b1;
        fd = t_dat[i];
      end
    if (tcam_clr) for (int i = 0; i < 16; i++) t_vld[i] <= 1'b0;
    if (tcam_req && !tcam_opcode) begin
      t_vld[tcam_addr] <= 1'b1;
      t_wrd[tcam_addr] <= tcam_word;
      t_msk[tcam_addr] <= tcam_mask;
      t_dat[tcam_addr] <= tcam_data;
    end
    if (rst) tcam_valid <= 1'b0;
    else if (tcam_ack) tcam_valid <= 1'b0;
    else if (tcam_req && tcam_opcode && f) begin
      tcam_valid    <= 1'b1;
      tcam_data_out <= fd;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tcam_req && tcam_opcode) srch_cycles++;
      if (tcam_clr) clr_cycles++;
      if (tcam_req && !tcam_opcode) begin
        if (wr_q.size() == 0) begin
          checks++;
          $display("FAIL write_strobe: unexpected write addr=%0h word=%0h", tcam_addr, tcam_word);
        end else check("write_operands", {tcam_addr, tcam_word, tcam_mask, tcam_data}, wr_q.pop_front());
      end
      if (m_done) begin
        check("m_done_expected", m_pending > 0, 1);
        if (m_pending > 0) m_pending--;
        order_q.push_back(0);
      end
      if (s0_done) begin
        order_q.push_back(1);
        if (s_q0.size() == 0) begin
          checks++;
          $display("FAIL s0_done: unexpected pulse, hit=%0b data=%0h", s0_hit, s0_data);
        end else begin
          last_res[0] = s_q0.pop_front();
          check("s0_result", {s0_hit, s0_data}, last_res[0]);
          check("s1_untouched", {s1_hit, s1_data}, last_res[1]);
        end
      end
      if (s1_done) begin
        order_q.push_back(2);
        if (s_q1.size() == 0) begin
          checks++;
          $display("FAIL s1_done: unexpected pulse, hit=%0b data=%0h", s1_hit, s1_data);
        end else begin
          last_res[1] = s_q1.pop_front();
          check("s1_result", {s1_hit, s1_data}, last_res[1]);
          check("s0_untouched", {s0_hit, s0_data}, last_res[0]);
        end
      end
    end
  end

  task automatic wait_done(input int which, input bit drop, output int lat);
    logic d;
    for (lat = 1; lat <= 200; lat++) begin
      @(negedge clk);
      d = (which == 0) ? m_done : (which == 1) ? s0_done : s1_done;
      if (d) break;
    end
    if (lat > 200) begin
      checks++;
      $display("FAIL wait_done_%0d: no done pulse within 200 cycles", which);
    end
    if (drop) begin
      @(posedge clk);
      #1;
      case (which)
        0: m_req = 1'b0;
        1: s0_req = 1'b0;
        default: s1_req = 1'b0;
      endcase
    end
  endtask

  task automatic do_mgmt(input bit op, input logic [AW-1:0] a, input logic [WW-1:0] w,
                         input logic [WW-1:0] mk, input logic [DW-1:0] d, input int lat_exp);
    int lat;
    @(posedge clk);
    #1;
    m_op = op; m_addr = a; m_word = w; m_mask = mk; m_data = d;
    m_pending++;
    if (!op) wr_q.push_back({a, w, mk, d});
    m_req = 1'b1;
    wait_done(0, 1'b1, lat);
    if (lat_exp != 0) check("m_latency", lat, lat_exp);
  endtask

  task automatic do_search(input int which, input logic [WW-1:0] w, input bit hit,
                           input logic [DW-1:0] d, input int n, input int lat_exp);
    int lat;
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++)
      if (which == 1) s_q0.push_back({hit, d}); else s_q1.push_back({hit, d});
    if (which == 1) begin s0_word = w; s0_req = 1'b1; end
    else begin s1_word = w; s1_req = 1'b1; end
    for (int k = 0; k < n; k++) begin
      wait_done(which, k == n - 1, lat);
      if (lat_exp != 0) check("search_latency", lat, lat_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    last_res[0] = '0;
    last_res[1] = '0;
    rst = 1'b1;
    m_req = 1'b1; m_op = 1'b0; m_addr = '0; m_word = 8'h5A; m_mask = 8'hFF; m_data = 8'h33;
    s0_req = 1'b1; s0_word = 8'h5A; s1_req = 1'b1; s1_word = 8'h5A;
    m_pending = 1;
    wr_q.push_back({4'h0, 8'h5A, 8'hFF, 8'h33});
    s_q0.push_back({1'b1, 8'h33});
    s_q1.push_back({1'b1, 8'h33});
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {m_done, s0_done, s1_done, s0_hit, s0_data, s1_hit, s1_data, busy,
                              tcam_req, tcam_opcode, tcam_clr, tcam_word, tcam_mask, tcam_addr,
                              tcam_data, tcam_ack}, 64'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    fork
      wait_done(0, 1'b1, l0);
      wait_done(1, 1'b1, l1);
      wait_done(2, 1'b1, l2);
    join
    check("reset_grant_order", enc_order(), 27);

    for (int i = 0; i < 8; i++)
      do_mgmt(1'b0, AW'(8 - i), WW'(i + 1), 8'hFF, DW'(8'hFF - i), 3);

    do_search(1, 8'h02, 1'b1, 8'hFE, 1, 0);

    srch_cycles = 0;
    do_search(2, 8'h80, 1'b0, 8'h00, 1, TO + 2);
    check("miss_req_cycles", srch_cycles, TO);
    void'(enc_order());

    fork
      do_mgmt(1'b0, 4'h9, 8'h10, 8'hFF, 8'h77, 0);
      do_search(1, 8'h03, 1'b1, 8'hFD, 1, 0);
      do_search(2, 8'h04, 1'b1, 8'hFC, 1, 0);
    join
    check("contention_order", enc_order(), 27);

    fork
      do_search(1, 8'h03, 1'b1, 8'hFD, 2, 0);
      do_search(2, 8'h04, 1'b1, 8'hFC, 2, 0);
    join
    check("alternation_order", enc_order(), 187);

    clr_cycles = 0;
    do_mgmt(1'b1, '0, '0, '0, '0, 3);
    check("clear_cycles", clr_cycles, 1);
    do_search(1, 8'h02, 1'b0, 8'h00, 1, TO + 2);

    @(posedge clk);
    #1;
    s0_word = 8'h02;
    s0_req = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_search", {busy, tcam_req}, 2'b11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_search", {busy, tcam_req, tcam_ack, s0_done}, 4'b0000);
    check("reset_clears_results", {s0_hit, s0_data, s1_hit, s1_data}, 18'h0);
    last_res[0] = '0;
    last_res[1] = '0;
    s0_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (TO + 8) @(negedge clk);
    check("queues_drained", wr_q.size() + s_q0.size() + s_q1.size() + m_pending, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
